// File: rtl/share_masker.sv
// -----------------------------------------------------------------------------
// share_masker
//
// Boolean 2-share masking encoder. Plain WIDTH-bit words are split into a
// registered share pair (share0 = data ^ mask, share1 = mask) for the masked
// AND/XOR datapath downstream. Masks are taken from an internal 32-bit Galois
// LFSR (x^32+x^22+x^2+x+1). The LFSR is seeded from an external entropy source
// and must be re-seeded after every RESEED_INTERVAL accepted words.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous, active-high reset
//   seed_valid  : seed word offered
//   seed        : 32-bit seed / entropy word
//   seed_ready  : seed accepted when seed_valid && seed_ready
//   in_valid    : plain word offered
//   in_data     : plain word
//   in_ready    : word accepted when in_valid && in_ready
//   out_valid   : share pair valid
//   out_share0  : in_data ^ mask
//   out_share1  : mask
//   out_ready   : downstream takes the pair when out_valid && out_ready
//   need_seed   : high while waiting for the first seed or a re-seed
//
// Parameters
//   WIDTH           : data/share width, 1..32
//   RESEED_INTERVAL : accepted words between mandatory re-seeds, >= 1
// -----------------------------------------------------------------------------
module share_masker #(
  parameter int WIDTH           = 8,
  parameter int RESEED_INTERVAL = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  output logic             seed_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_share0,
  output logic [WIDTH-1:0] out_share1,
  input  logic             out_ready,
  output logic             need_seed
);

  // Galois feedback mask for x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [1:0] ST_UNSEEDED = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_RESEED   = 2'd2;

  // The counter only needs to represent 0..RESEED_INTERVAL-1: it wraps to 0
  // on the accept that completes an interval.
  localparam int                CNT_W    = (RESEED_INTERVAL > 1) ? $clog2(RESEED_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RESEED_INTERVAL - 1);

  // ---------------------------------------------------------------------------
  // LFSR helper: advance the generator WIDTH single steps. Unrolled at
  // elaboration into a pure XOR network, so a whole word's worth of mask bits
  // is consumed in one cycle.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] lfsr_advance(input logic [31:0] state);
    logic [31:0] v;
    // NOTE: blocking assignments inside functions and always_comb model a
    // chain of combinational steps; each line sees the previous line's value.
    v = state;
    for (int i = 0; i < WIDTH; i++) begin
      v = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [31:0]      r_lfsr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_share0;
  logic [WIDTH-1:0] r_share1;

  // ---------------------------------------------------------------------------
  // Handshake and datapath wires
  // ---------------------------------------------------------------------------
  logic             w_run;
  logic             w_in_ready;
  logic             w_seed_ready;
  logic             w_accept;
  logic             w_seed_take;
  logic             w_drain;
  logic             w_last_word;
  logic [WIDTH-1:0] w_mask;
  logic [31:0]      w_lfsr_stepped;
  logic [31:0]      w_reseed_mix;
  logic [31:0]      w_seed_value;

  assign w_run        = (r_state == ST_RUN);

  // The output register is one deep: a new word may enter only when the slot
  // is empty or is being emptied in this very cycle, giving 1 word/cycle when
  // downstream keeps out_ready high.
  assign w_in_ready   = w_run && (!r_out_valid || out_ready);
  assign w_seed_ready = !w_run;

  assign w_accept     = in_valid && w_in_ready;
  assign w_seed_take  = seed_valid && w_seed_ready;
  assign w_drain      = r_out_valid && out_ready;

  assign w_last_word  = (r_count == CNT_LAST);

  // The mask is the LFSR state before this cycle's advance.
  assign w_mask         = r_lfsr[WIDTH-1:0];
  assign w_lfsr_stepped = lfsr_advance(r_lfsr);
  assign w_reseed_mix   = r_lfsr ^ seed;

  // An all-zero state would lock the LFSR at zero forever (and emit an
  // all-zero mask), so both the initial seed and the re-seed mix are forced
  // to 1 if they come out zero.
  always_comb begin
    // NOTE: a default assignment on entry to always_comb guarantees every
    // path drives the signal, so no latch can be inferred.
    w_seed_value = 32'h0000_0001;
    if (r_state == ST_UNSEEDED) begin
      if (seed != 32'h0) w_seed_value = seed;
    end else begin
      if (w_reseed_mix != 32'h0) w_seed_value = w_reseed_mix;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: state, word counter and LFSR
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNSEEDED;
      r_lfsr  <= 32'h0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_UNSEEDED: begin
          if (w_seed_take) begin
            r_lfsr  <= w_seed_value;
            r_count <= '0;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Seeds are ignored here (seed_ready is low); the LFSR only moves
          // on an accepted word.
          if (w_accept) begin
            r_lfsr <= w_lfsr_stepped;
            if (w_last_word) begin
              r_count <= '0;
              r_state <= ST_RESEED;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end

        ST_RESEED: begin
          // Mixing rather than replacing keeps the accumulated entropy even
          // if a single seed word is weak.
          if (w_seed_take) begin
            r_lfsr  <= w_seed_value;
            r_state <= ST_RUN;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a safe, unseeded state.
          r_state <= ST_UNSEEDED;
          r_lfsr  <= 32'h0;
          r_count <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one-deep share register
  // ---------------------------------------------------------------------------
  // The XOR with the mask sits directly at the register input, so in_data is
  // never captured anywhere in its plain form. The pair holds while the slot
  // is full and downstream stalls; a drain without a simultaneous accept
  // empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_share0    <= '0;
      r_share1    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_share0    <= in_data ^ w_mask;
      r_share1    <= w_mask;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign seed_ready = w_seed_ready;
  assign in_ready   = w_in_ready;
  assign need_seed  = !w_run;
  assign out_valid  = r_out_valid;
  assign out_share0 = r_share0;
  assign out_share1 = r_share1;

endmodule

// File: tb/tb_share_masker.sv
// -----------------------------------------------------------------------------
// tb_share_masker
//
// Self-checking bench for share_masker (WIDTH=8, RESEED_INTERVAL=4). A
// transaction-level reference model (seeded flag, words since seed, pending
// pair, queue of accepted plain words) predicts every handshake and share
// value; directed steps cover the basic, zero-seed, backpressure, re-seed and
// mid-operation reset cases, followed by a randomized soak.
// -----------------------------------------------------------------------------
module tb_share_masker;

  localparam int WIDTH    = 8;
  localparam int INTERVAL = 4;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic             clk;
  logic             rst;
  logic             seed_valid;
  logic [31:0]      seed;
  logic             seed_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_share0;
  logic [WIDTH-1:0] out_share1;
  logic             out_ready;
  logic             need_seed;

  share_masker #(
    .WIDTH           (WIDTH),
    .RESEED_INTERVAL (INTERVAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_share0 (out_share0),
    .out_share1 (out_share1),
    .out_ready  (out_ready),
    .need_seed  (need_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [31:0]      m_lfsr;
  bit               m_unseeded;
  bit               m_need;
  int               m_count;
  bit               m_ov;
  logic [WIDTH-1:0] m_s0;
  logic [WIDTH-1:0] m_s1;
  logic [WIDTH-1:0] exp_q[$];

  bit last_acc;
  bit prev_need;
  bit count_rises;
  int rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] x, input int n);
    logic [31:0] v = x;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    return v;
  endfunction

  // One clock cycle: compare at the falling edge, predict the rising-edge
  // outcome, return 1 time unit after the rising edge.
  task automatic tick();
    bit               acc, sacc, drain, mi_ready;
    logic [WIDTH-1:0] plain, mask;
    @(negedge clk);
    mi_ready = !m_need && (!m_ov || out_ready);
    check("in_ready",   in_ready,   mi_ready);
    check("seed_ready", seed_ready, m_need);
    check("need_seed",  need_seed,  m_need);
    check("out_valid",  out_valid,  m_ov);
    if (m_ov) begin
      check("out_share0", out_share0, m_s0);
      check("out_share1", out_share1, m_s1);
    end
    if (count_rises && need_seed && !prev_need) rises++;
    prev_need = need_seed;

    acc   = in_valid && mi_ready;
    sacc  = seed_valid && m_need;
    drain = m_ov && out_ready;

    if (drain) begin
      check("pair_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        plain = exp_q.pop_front();
        check("share_xor", out_share0 ^ out_share1, plain);
      end
    end
    if (sacc) begin
      if (m_unseeded) m_lfsr = (seed == 0) ? 32'h1 : seed;
      else begin
        m_lfsr = m_lfsr ^ seed;
        if (m_lfsr == 0) m_lfsr = 32'h1;
      end
      m_unseeded = 0;
      m_need     = 0;
      m_count    = 0;
    end
    if (acc) begin
      mask = m_lfsr[WIDTH-1:0];
      m_s1 = mask;
      m_s0 = in_data ^ mask;
      m_ov = 1;
      exp_q.push_back(in_data);
      m_lfsr = lfsr_adv(m_lfsr, WIDTH);
      m_count++;
      if (m_count == INTERVAL) begin
        m_need  = 1;
        m_count = 0;
      end
    end else if (drain) begin
      m_ov = 0;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset from wherever the bench currently is in the cycle;
  // outputs must clear without waiting for a clock edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_out_valid"}, out_valid,  0);
    check({tag, "_share0"},    out_share0, 0);
    check({tag, "_share1"},    out_share1, 0);
    check({tag, "_need_seed"}, need_seed,  1);
    check({tag, "_in_ready"},  in_ready,   0);
    m_lfsr     = 32'h0;
    m_unseeded = 1;
    m_need     = 1;
    m_count    = 0;
    m_ov       = 0;
    m_s0       = '0;
    m_s1       = '0;
    exp_q.delete();
    last_acc   = 0;
    prev_need  = 1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_mask;
    int               soak_acc;
    int               cycles;

    rst = 1'b0; seed_valid = 1'b0; seed = 32'h0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    count_rises = 0; rises = 0;
    #2;
    apply_reset("reset");

    // Basic masking: word offered together with the seed stalls one cycle.
    seed_valid = 1; seed = 32'h0000_00A5;
    in_valid = 1; in_data = 8'h3C;
    tick();
    seed_valid = 0;
    tick();
    in_valid = 0;
    check("basic_valid",  out_valid,  1);
    check("basic_share1", out_share1, 8'hA5);
    check("basic_share0", out_share0, 8'h99);
    tick();

    // Zero seed is replaced by 1.
    apply_reset("reset2");
    seed_valid = 1; seed = 32'h0;
    in_valid = 1; in_data = 8'hFF;
    tick();
    seed_valid = 0;
    tick();
    in_valid = 0;
    check("zero_seed_share1", out_share1, 8'h01);
    check("zero_seed_share0", out_share0, 8'hFE);
    tick();                                  // drains; word count is 1

    // Backpressure: second word waits while the first pair is held.
    out_ready = 0;
    in_valid = 1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    tick();
    check("bp_in_ready", in_ready,  0);
    check("bp_held",     out_share0 ^ out_share1, 8'h11);
    out_ready = 1;
    tick();                                  // drain + accept together
    check("bp_same_cycle_valid", out_valid, 1);
    check("bp_second_word",      out_share0 ^ out_share1, 8'h22);

    // Fourth word triggers the re-seed request; its pair still drains.
    in_data = 8'h33;
    tick();
    in_data = 8'h44;
    check("reseed_need",     need_seed, 1);
    check("reseed_in_ready", in_ready,  0);
    check("reseed_pending",  out_valid, 1);
    tick();
    check("reseed_drained",  out_valid, 0);
    seed_valid = 1; seed = 32'h1234_5678;
    exp_mask = (((m_lfsr ^ seed) == 0) ? 32'h1 : (m_lfsr ^ seed)) & 32'hFF;
    tick();
    seed_valid = 0;
    tick();
    check("reseed_mask", out_share1, exp_mask);
    check("reseed_word", out_share0 ^ out_share1, 8'h44);

    // Re-seed whose mix is zero must land on 1.
    for (int i = 0; i < 20 && !m_need; i++) begin
      in_data = WIDTH'($urandom);
      tick();
    end
    check("zero_mix_need", need_seed, 1);
    seed_valid = 1; seed = m_lfsr;
    tick();
    seed_valid = 0;
    in_data = 8'h5A;
    tick();
    check("zero_mix_mask", out_share1, 8'h01);

    // Reset while a pair is stalled at the output.
    out_ready = 0;
    in_data = 8'h77;
    tick();
    in_valid = 0;
    check("midop_pending", out_valid, 1);
    #2;
    apply_reset("midop");
    out_ready = 1;
    tick();
    tick();
    check("midop_no_stale", out_valid, 0);

    // Random soak.
    count_rises = 1;
    rises    = 0;
    soak_acc = 0;
    cycles   = 0;
    while (soak_acc < 1000 && cycles < 20000) begin
      out_ready = ($urandom % 4) != 0;
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom % 4) != 0;
        in_data  = WIDTH'($urandom);
      end
      seed_valid = ($urandom % 3) == 0;
      seed       = (($urandom % 8) == 0) ? 32'h0 : $urandom;
      tick();
      if (last_acc) soak_acc++;
      cycles++;
    end
    in_valid = 0; seed_valid = 0; out_ready = 1;
    tick();
    tick();
    tick();
    check("soak_words",   soak_acc, 1000);
    check("soak_reseeds", rises, soak_acc / INTERVAL);
    check("soak_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/share_masker.md
Name: share_masker

Overview:
- Boolean 2-share masking encoder: takes plain WIDTH-bit words and emits registered share pairs (share0 = data ^ mask, share1 = mask) for the masked gate datapath.
- Masks come from an internal 32-bit Galois LFSR, seeded and periodically re-seeded from an external entropy source.
- Sits upstream of masked AND/XOR stages and is the producing end of the share interface those stages consume.

Parameters:
- WIDTH, 8, data/share width in bits; legal range 1..32.
- RESEED_INTERVAL, 256, number of accepted words after which a fresh seed is mandatory; minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seed_valid  input  1  seed word offered.
- seed  input  32  seed / entropy word.
- seed_ready  output  1  seed accepted this cycle when seed_valid && seed_ready.
- in_valid  input  1  plain word offered.
- in_data  input  WIDTH  plain word.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- out_valid  output  1  share pair valid.
- out_share0  output  WIDTH  in_data ^ mask.
- out_share1  output  WIDTH  mask.
- out_ready  input  1  downstream accepts the pair when out_valid && out_ready.
- need_seed  output  1  high in UNSEEDED and RESEED states.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state=UNSEEDED, lfsr=0, word counter=0, out_valid=0, out_share0=0, out_share1=0.
  - In-flight output pair is discarded.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, feedback mask 32'h80200003.
  - One step: if lfsr[0], then lfsr = (lfsr>>1) ^ 32'h80200003; else lfsr = lfsr>>1.
  - Per accepted word: mask = lfsr[WIDTH-1:0] (state before the update), then lfsr advances WIDTH steps in the same cycle.
  - The LFSR never advances otherwise.
- State UNSEEDED:
  - seed_ready=1, in_ready=0, need_seed=1.
  - On seed handshake: lfsr <= seed, or 32'h1 if seed==0. Counter <= 0. Next state RUN.
- State RUN:
  - seed_ready=0, need_seed=0.
  - in_ready = !out_valid || out_ready (combinational pass-through of downstream ready).
  - On word handshake: out_share0 <= in_data ^ mask, out_share1 <= mask, out_valid <= 1, counter++.
  - If the counter reaches RESEED_INTERVAL on this accept, next state RESEED and counter <= 0.
- State RESEED:
  - in_ready=0, seed_ready=1, need_seed=1.
  - The pending output still drains normally.
  - On seed handshake: lfsr <= lfsr ^ seed; if the result is 0, lfsr <= 32'h1. Next state RUN.
- Output stage:
  - One-deep register, latency 1 cycle from accept to out_valid.
  - Pair holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new word is accepted in the same cycle. Simultaneous drain+accept gives full throughput, 1 word/cycle.
- Invariants:
  - out_share0 ^ out_share1 == accepted in_data for every pair.
  - Plain data is never stored unmasked: no register holds in_data alone.
  - share0 and share1 are computed from mask and data only in the output register input logic.
- Seed presented in RUN: ignored (seed_ready=0). Word presented in UNSEEDED/RESEED: stalled, not dropped.

Test Plan:
- Basic masking: reset, seed=32'h000000A5, then in_data=8'h3C -> one cycle later out_valid=1, out_share1=8'hA5, out_share0=8'h99.
- Zero seed: seed=32'h0, in_data=8'hFF -> out_share1=8'h01, out_share0=8'hFE; lfsr never becomes 0.
- Backpressure: out_ready=0, two words offered back-to-back -> first pair held stable, in_ready=0, second word waits. out_ready=1 -> first pair drains and second word is accepted in the same cycle. Shares match a reference model.
- Reseed, with RESEED_INTERVAL=4: after 4th accepted word, in_ready=0 and need_seed=1. The 4th pair still drains. A seed handshake returns to RUN, and the next mask equals the model's (lfsr ^ seed) low byte.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> out_valid, out_share0 and out_share1 go to 0 immediately, need_seed=1, no stale pair after release.
- Random soak: 1000 random words, random out_ready -> share0^share1==in_data for every pair, no drops or duplicates, need_seed asserted exactly every RESEED_INTERVAL words.
